fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the register file. It holds the program counter and fetches instructions from instruction memory over a req/ack handshake. It presents each instruction with its address, and drives the register file's R15 input with the architectural PC+8 value for the instruction currently presented. Branch redirects and downstream stalls are handled here, so decode never sees a stale or wrong-path instruction.

## Interface
- N, 32, data/address width
- RESET_PC, 0, PC value loaded on reset; must be word-aligned

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- imem_req  out  1  fetch request; held high until acknowledged or redirected
- imem_addr  out  N  fetch address; equals pc while imem_req=1
- imem_ack  in  1  memory returns imem_rdata for imem_addr this cycle
- imem_rdata  in  N  fetched instruction word
- stall  in  1  decode cannot accept; hold the presented instruction
- branch_en  in  1  redirect fetch this cycle
- branch_target  in  N  redirect address; bits [1:0] ignored and forced to 0
- instr  out  N  presented instruction
- instr_valid  out  1  instr/instr_pc/r15 are meaningful
- instr_pc  out  N  address of presented instruction
- r15  out  N  instr_pc + 8, fed to the register file R15 input

## Operation
- Registers:
  - pc: next fetch address
  - state: IDLE, WAIT or VALID
  - instr, instr_pc, r15 and instr_valid: all registered outputs
- All address arithmetic is modulo 2^N: pc+4 and instr_pc+8 wrap silently (0xFFFFFFFC+4 = 0).
- State behaviour:
  - IDLE: imem_req=0. Next cycle goes to WAIT. Entered only from reset.
  - WAIT: imem_req=1, imem_addr=pc. On imem_ack=1 and branch_en=0:
    - instr<=imem_rdata, instr_pc<=pc, r15<=pc+8, instr_valid<=1, pc<=pc+4
    - go to VALID
  - WAIT without ack: stay in WAIT; pc and outputs unchanged. stall is ignored in WAIT.
  - VALID: instr_valid=1, imem_req=0.
    - stall=1: hold every output and stay in VALID.
    - stall=0: the instruction is consumed at this edge; instr_valid<=0, go to WAIT.
- Branch (branch_en=1) has highest priority over ack, stall and state:
  - pc<={branch_target[N-1:2],2'b00}, instr_valid<=0, go to WAIT
  - Any imem_rdata acknowledged in the same cycle is discarded.
  - instr, instr_pc and r15 keep their old values but are invalid.
- Memory must tolerate imem_addr changing or imem_req dropping without ack. An ack applies only to the address presented in that same cycle.
- Reset (rst=0, any time, including mid-fetch): immediately and asynchronously:
  - state=IDLE, pc=RESET_PC
  - imem_req=0, instr=0, instr_valid=0
  - instr_pc=RESET_PC, r15=RESET_PC+8
- imem_addr always equals pc, including in reset.

## Timing
- imem_req, imem_addr, instr_valid, instr, instr_pc and r15 are all functions of registered state only; no combinational path from inputs to outputs.
- Sequence after rst deasserts: cycle 0 IDLE, cycle 1 WAIT (req=1).
- Fetch latency: the instruction appears with instr_valid=1 the cycle after the ack edge.
- Peak throughput is one instruction per 2 cycles with zero-wait memory: WAIT, then VALID.
- Branch penalty: a branch in any cycle puts the target request on imem_req the next cycle.
- r15 updates together with instr_pc, so the register file sees a stable R15 for the whole time an instruction is presented.
- A stall lasting k cycles in VALID extends VALID by exactly k cycles with outputs constant.

## Test plan
- Reset, then zero-wait memory returning addr^0xA5A5A5A5 → instr_pc = 0,4,8,12 on successive VALID cycles; r15 = 8,12,16,20; imem_req high only in WAIT cycles.
- Memory acks after 3 wait cycles → imem_req stays high with imem_addr=pc for 4 cycles; instr appears the cycle after the ack; pc advances by exactly 4.
- stall=1 for 5 cycles during VALID with instr_pc=0x10 → instr, instr_pc=0x10 and r15=0x18 stay constant for 5 cycles; WAIT at 0x14 follows the stall release.
- branch_en=1, target 0x103, same cycle as imem_ack → rdata discarded, instr_valid=0; next cycle imem_addr=0x100; next valid instr_pc=0x100, r15=0x108.
- RESET_PC=0xFFFFFFFC → first instr_pc=0xFFFFFFFC with r15=0x00000004; second fetch address is 0x00000000.
- rst pulled low mid-WAIT and mid-VALID-stall → imem_req=0, instr_valid=0 and pc=RESET_PC immediately without a clock edge; normal fetch resumes from RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly upstream of the register file.
// Holds the program counter, fetches instruction words from instruction
// memory over a simple req/ack handshake, and presents each fetched word
// together with its address and the architectural PC+8 value that the
// register file uses as its R15 input.
//
// Branch redirects and downstream stalls are resolved here, so decode never
// sees a stale or wrong-path instruction.
//
// Parameters
//   N         data / address width
//   RESET_PC  PC loaded on reset (must be word-aligned)
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   imem_req       fetch request, high only while waiting for memory
//   imem_addr      fetch address, always equal to the internal pc
//   imem_ack       memory returns imem_rdata for imem_addr this cycle
//   imem_rdata     fetched instruction word
//   stall          decode cannot accept the presented instruction
//   branch_en      redirect fetch this cycle (highest priority)
//   branch_target  redirect address, low two bits ignored
//   instr          presented instruction
//   instr_valid    instr / instr_pc / r15 are meaningful
//   instr_pc       address of the presented instruction
//   r15            instr_pc + 8, fed to the register file R15 input
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned     N        = 32,
  parameter logic [N-1:0]    RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  input  logic         stall,
  input  logic         branch_en,
  input  logic [N-1:0] branch_target,
  output logic [N-1:0] instr,
  output logic         instr_valid,
  output logic [N-1:0] instr_pc,
  output logic [N-1:0] r15
);

  // Address increments. Plain N-bit addition gives the required modulo-2^N
  // wrap (0xFFFFFFFC + 4 = 0).
  localparam logic [N-1:0] PC_STEP   = N'(4);
  localparam logic [N-1:0] R15_OFS   = N'(8);
  localparam logic [N-1:0] ALIGN_MSK = ~N'(3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // one cycle after reset, no request
    ST_WAIT  = 2'd1,  // request outstanding at pc
    ST_VALID = 2'd2   // instruction presented to decode
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] instr_pc_q, instr_pc_d;
  logic [N-1:0] r15_q, r15_d;
  logic         instr_valid_q, instr_valid_d;

  // Redirect address with the byte-offset bits cleared.
  logic [N-1:0] branch_pc;
  assign branch_pc = branch_target & ALIGN_MSK;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    r15_d         = r15_q;
    instr_valid_d = instr_valid_q;

    if (branch_en) begin
      // A redirect overrides everything: any word acknowledged this cycle
      // belongs to the wrong path and is dropped. instr/instr_pc/r15 keep
      // their old contents but are marked invalid.
      pc_d          = branch_pc;
      instr_valid_d = 1'b0;
      state_d       = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
        end

        ST_WAIT: begin
          // stall has no effect here; nothing is presented yet.
          if (imem_ack) begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            r15_d         = pc_q + R15_OFS;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + PC_STEP;
            state_d       = ST_VALID;
          end
        end

        ST_VALID: begin
          // Without a stall, decode consumes the instruction at this edge
          // and the next fetch starts immediately.
          if (!stall) begin
            instr_valid_d = 1'b0;
            state_d       = ST_WAIT;
          end
        end

        default: begin
          state_d       = ST_IDLE;
          instr_valid_d = 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= RESET_PC;
      r15_q         <= RESET_PC + R15_OFS;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      r15_q         <= r15_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (registered state only)
  // -------------------------------------------------------------------------
  assign imem_req    = (state_q == ST_WAIT);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign r15         = r15_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Two fetch units (RESET_PC = 0 and RESET_PC = 0xFFFFFFFC) share one stimulus
// stream. Each has its own memory returning addr ^ 0xA5A5A5A5 and its own
// behavioural model. Every cycle the outputs of both are compared against
// their models; directed sections add literal expectations.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ack, stall, br;
  logic [31:0] tgt;

  logic        req_w   [2];
  logic [31:0] addr_w  [2];
  logic [31:0] rdata_w [2];
  logic [31:0] instr_w [2];
  logic        vld_w   [2];
  logic [31:0] ipc_w   [2];
  logic [31:0] r15_w   [2];

  assign rdata_w[0] = addr_w[0] ^ KEY;
  assign rdata_w[1] = addr_w[1] ^ KEY;

  fetch_unit #(.N(32), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst),
    .imem_req(req_w[0]), .imem_addr(addr_w[0]),
    .imem_ack(ack), .imem_rdata(rdata_w[0]),
    .stall(stall), .branch_en(br), .branch_target(tgt),
    .instr(instr_w[0]), .instr_valid(vld_w[0]),
    .instr_pc(ipc_w[0]), .r15(r15_w[0])
  );

  fetch_unit #(.N(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst),
    .imem_req(req_w[1]), .imem_addr(addr_w[1]),
    .imem_ack(ack), .imem_rdata(rdata_w[1]),
    .stall(stall), .branch_en(br), .branch_target(tgt),
    .instr(instr_w[1]), .instr_valid(vld_w[1]),
    .instr_pc(ipc_w[1]), .r15(r15_w[1])
  );

  // Behavioural model: what each unit is doing, expressed as booleans
  // (requesting / presenting / just out of reset) plus the values it holds.
  logic [31:0] m_pc [2], m_instr [2], m_ipc [2], m_r15 [2];
  bit          m_idle [2], m_req [2], m_vld [2];

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] rp(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d]    = rp(d);
      m_instr[d] = '0;
      m_ipc[d]   = rp(d);
      m_r15[d]   = rp(d) + 32'd8;
      m_idle[d]  = 1'b1;
      m_req[d]   = 1'b0;
      m_vld[d]   = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_req", d),   32'(req_w[d]), 32'(m_req[d]));
      chk($sformatf("d%0d_addr", d),  addr_w[d],     m_pc[d]);
      chk($sformatf("d%0d_valid", d), 32'(vld_w[d]), 32'(m_vld[d]));
      chk($sformatf("d%0d_instr", d), instr_w[d],    m_instr[d]);
      chk($sformatf("d%0d_ipc", d),   ipc_w[d],      m_ipc[d]);
      chk($sformatf("d%0d_r15", d),   r15_w[d],      m_r15[d]);
    end
  endtask

  // Advance the model by one clock edge using the inputs now being driven.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (br) begin
        m_pc[d]   = {tgt[31:2], 2'b00};
        m_vld[d]  = 1'b0;
        m_req[d]  = 1'b1;
        m_idle[d] = 1'b0;
      end else if (m_idle[d]) begin
        m_idle[d] = 1'b0;
        m_req[d]  = 1'b1;
      end else if (m_req[d]) begin
        if (ack) begin
          m_instr[d] = m_pc[d] ^ KEY;
          m_ipc[d]   = m_pc[d];
          m_r15[d]   = m_pc[d] + 32'd8;
          m_vld[d]   = 1'b1;
          m_req[d]   = 1'b0;
          m_pc[d]    = m_pc[d] + 32'd4;
        end
      end else if (m_vld[d] && !stall) begin
        m_vld[d] = 1'b0;
        m_req[d] = 1'b1;
      end
    end
  endtask

  // Called on a falling edge: check, drive, step model, wait one cycle.
  task automatic cycle(input bit a_i, input bit s_i, input bit b_i, input logic [31:0] t_i);
    check_all();
    ack   = a_i;
    stall = s_i;
    br    = b_i;
    tgt   = t_i;
    model_step();
    $display("[TB] t=%0t ack=%0b stall=%0b br=%0b tgt=%08h | d0 pc=%08h vld=%0b ipc=%08h | d1 pc=%08h vld=%0b ipc=%08h",
             $time, a_i, s_i, b_i, t_i, m_pc[0], m_vld[0], m_ipc[0], m_pc[1], m_vld[1], m_ipc[1]);
    @(negedge clk);
  endtask

  // Pull reset low between edges and check the outputs react without a clock.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_arst_req", d),   32'(req_w[d]), 32'd0);
      chk($sformatf("d%0d_arst_valid", d), 32'(vld_w[d]), 32'd0);
      chk($sformatf("d%0d_arst_addr", d),  addr_w[d],     rp(d));
      chk($sformatf("d%0d_arst_instr", d), instr_w[d],    32'd0);
      chk($sformatf("d%0d_arst_ipc", d),   ipc_w[d],      rp(d));
      chk($sformatf("d%0d_arst_r15", d),   r15_w[d],      rp(d) + 32'd8);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    ack   = 1'b0;
    stall = 1'b0;
    br    = 1'b0;
    tgt   = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait memory: WAIT/VALID alternating from the reset PC.
    for (int c = 0; c <= 8; c++) begin
      if (c == 0) begin
        chk("lit_idle_req0", 32'(req_w[0]), 32'd0);
        chk("lit_idle_req1", 32'(req_w[1]), 32'd0);
      end else if (c % 2 == 1) begin
        chk("lit_wait_req", 32'(req_w[0]), 32'd1);
        chk("lit_wait_addr", addr_w[0], 32'(4 * ((c - 1) / 2)));
        if (c == 3) chk("lit_wrap_addr", addr_w[1], 32'h0000_0000);
      end else begin
        chk("lit_vld", 32'(vld_w[0]), 32'd1);
        chk("lit_ipc", ipc_w[0], 32'(4 * ((c - 2) / 2)));
        chk("lit_r15", r15_w[0], 32'(4 * ((c - 2) / 2) + 8));
        chk("lit_instr", instr_w[0], 32'(4 * ((c - 2) / 2)) ^ 32'hA5A5A5A5);
        chk("lit_req_lo", 32'(req_w[0]), 32'd0);
        if (c == 2) begin
          chk("lit_wrap_ipc", ipc_w[1], 32'hFFFF_FFFC);
          chk("lit_wrap_r15", r15_w[1], 32'h0000_0004);
        end
      end
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
    end

    // Branch to 0x103 in the same cycle as an ack.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    for (int d = 0; d < 2; d++) begin
      chk("lit_br_addr", addr_w[d], 32'h0000_0100);
      chk("lit_br_req", 32'(req_w[d]), 32'd1);
      chk("lit_br_vld", 32'(vld_w[d]), 32'd0);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("lit_br_ipc", ipc_w[0], 32'h0000_0100);
    chk("lit_br_r15", r15_w[0], 32'h0000_0108);

    // Five-cycle stall holds the presented instruction.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("lit_stall_vld", 32'(vld_w[0]), 32'd1);
      chk("lit_stall_ipc", ipc_w[0], 32'h0000_0100);
      chk("lit_stall_r15", r15_w[0], 32'h0000_0108);
      chk("lit_stall_instr", instr_w[0], 32'h0000_0100 ^ 32'hA5A5A5A5);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_after_stall_addr", addr_w[0], 32'h0000_0104);

    // Memory acks after three wait cycles.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      chk("lit_slow_req", 32'(req_w[0]), 32'd1);
      chk("lit_slow_addr", addr_w[0], 32'h0000_0104);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("lit_slow_ipc", ipc_w[0], 32'h0000_0104);
    chk("lit_slow_pc", addr_w[0], 32'h0000_0108);

    // Reset mid-WAIT.
    async_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    async_reset();
    // Reset mid-VALID-stall.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("lit_resume_ipc", ipc_w[0], 32'h0000_0000);
    chk("lit_resume_vld", 32'(vld_w[0]), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cycle(($urandom_range(0, 1) == 1),
              ($urandom_range(0, 9) < 3),
              ($urandom_range(0, 11) == 0),
              $urandom);
      end
    end
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
